// File: rtl/axi_lite_mem_master_if.sv
// AXI-lite channel bundle shared by the memory master and the block-RAM slave.
interface axi_lite_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_mem_master.sv
// Single-outstanding core memory request port bridged onto an AXI-lite master;
// one request becomes one AR/R or AW/W/B transaction and a one-cycle response.
module axi_lite_mem_master #(
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [STRB_WIDTH-1:0] req_wstrb,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   axi_lite_if.master            m_axi
);

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_AW_W,
      S_B
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [31:0]           r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_WIDTH-1:0] r_wstrb;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;

   logic                  w_accept;
   logic                  w_misalign;
   logic                  w_arvalid;
   logic                  w_rready;
   logic                  w_awvalid;
   logic                  w_wvalid;
   logic                  w_bready;
   logic                  w_ar_hs;
   logic                  w_r_hs;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_b_hs;
   logic                  w_aw_now;
   logic                  w_w_now;

   always_comb begin
      w_accept   = req_valid && (r_state == S_IDLE);
      w_misalign = (req_addr[1:0] != 2'b00);

      w_arvalid  = (r_state == S_AR);
      w_rready   = (r_state == S_R);
      w_awvalid  = (r_state == S_AW_W) && !r_aw_done;
      w_wvalid   = (r_state == S_AW_W) && !r_w_done;
      w_bready   = (r_state == S_B);

      w_ar_hs    = w_arvalid && m_axi.arready;
      w_r_hs     = w_rready  && m_axi.rvalid;
      w_aw_hs    = w_awvalid && m_axi.awready;
      w_w_hs     = w_wvalid  && m_axi.wready;
      w_b_hs     = w_bready  && m_axi.bvalid;

      // A handshake in the current cycle counts as done for the B transition.
      w_aw_now   = r_aw_done || w_aw_hs;
      w_w_now    = r_w_done  || w_w_hs;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept && !w_misalign) w_state_nxt = req_we ? S_AW_W : S_AR;
         S_AR:   if (w_ar_hs) w_state_nxt = S_R;
         S_R:    if (w_r_hs) w_state_nxt = S_IDLE;
         S_AW_W: if (w_aw_now && w_w_now) w_state_nxt = S_B;
         S_B:    if (w_b_hs) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;

         if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            if (w_misalign) begin
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b1;
               r_rsp_rdata <= '0;
            end
         end

         if (w_r_hs) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= m_axi.rdata;
            r_rsp_err   <= (m_axi.rresp != RESP_OKAY);
         end

         if (r_state == S_AW_W) begin
            if (w_aw_now && w_w_now) begin
               r_aw_done <= 1'b0;
               r_w_done  <= 1'b0;
            end else begin
               r_aw_done <= w_aw_now;
               r_w_done  <= w_w_now;
            end
         end

         if (w_b_hs) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= (m_axi.bresp != RESP_OKAY);
         end
      end
   end

   assign req_ready     = (r_state == S_IDLE);
   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_err       = r_rsp_err;

   assign m_axi.araddr  = r_addr;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arvalid = w_arvalid;
   assign m_axi.rready  = w_rready;
   assign m_axi.awaddr  = r_addr;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = w_awvalid;
   assign m_axi.wdata   = r_wdata;
   assign m_axi.wstrb   = r_wstrb;
   assign m_axi.wvalid  = w_wvalid;
   assign m_axi.bready  = w_bready;

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Bench for axi_lite_mem_master: block-RAM style AXI-lite slave model, a reference
// memory and a response scoreboard checking data, error flag and latency.
module tb_axi_lite_mem_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   always #5 clk = ~clk;

   axi_lite_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   axi_lite_mem_master #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .m_axi     (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- slave model ----------------
   logic [31:0] mem [0:255];
   logic [31:0] ref_mem [0:255];
   logic        stub;
   logic        ld_en;
   logic [7:0]  ld_idx;
   logic [31:0] ld_val;
   logic        aw_got, w_got;
   logic [31:0] s_wa, s_wd;
   logic [3:0]  s_ws;

   logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
   assign ar_hs = bus.arvalid && bus.arready;
   assign r_hs  = bus.rvalid  && bus.rready;
   assign aw_hs = bus.awvalid && bus.awready;
   assign w_hs  = bus.wvalid  && bus.wready;
   assign b_hs  = bus.bvalid  && bus.bready;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (ld_en) mem[ld_idx] <= ld_val;
      if (rst) begin
         bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= 2'b00;
         bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
         aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
         if (ar_hs) begin
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b1;
            bus.rdata   <= mem[bus.araddr[9:2]];
            bus.rresp   <= stub ? 2'b11 : 2'b00;
         end else if (bus.arvalid && !bus.arready && !bus.rvalid) bus.arready <= 1'b1;
         if (r_hs) bus.rvalid <= 1'b0;

         // Normal mode takes AW then W; stub mode takes W first.
         if (aw_hs) begin
            bus.awready <= 1'b0; aw_got <= 1'b1; s_wa <= bus.awaddr;
         end else if (bus.awvalid && !bus.awready && !aw_got && (!stub || w_got || w_hs))
            bus.awready <= 1'b1;
         if (w_hs) begin
            bus.wready <= 1'b0; w_got <= 1'b1; s_wd <= bus.wdata; s_ws <= bus.wstrb;
         end else if (bus.wvalid && !bus.wready && !w_got && (stub || aw_got || aw_hs))
            bus.wready <= 1'b1;

         if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            aw_got <= 1'b0; w_got <= 1'b0;
            bus.bvalid <= 1'b1;
            bus.bresp  <= stub ? 2'b10 : 2'b00;
            if (!stub)
               mem[(aw_hs ? bus.awaddr[9:2] : s_wa[9:2])] <=
                  merge(mem[(aw_hs ? bus.awaddr[9:2] : s_wa[9:2])],
                        w_hs ? bus.wdata : s_wd, w_hs ? bus.wstrb : s_ws);
         end
         if (b_hs) bus.bvalid <= 1'b0;
      end
   end

   // ---------------- monitors ----------------
   int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, arv_cnt = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ar_hs) ar_cnt <= ar_cnt + 1;
      if (r_hs)  r_cnt  <= r_cnt + 1;
      if (aw_hs) aw_cnt <= aw_cnt + 1;
      if (w_hs)  w_cnt  <= w_cnt + 1;
      if (b_hs)  b_cnt  <= b_cnt + 1;
      if (bus.arvalid) arv_cnt <= arv_cnt + 1;
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;
   exp_t sbq[$];
   logic [31:0] last_rdata;
   logic        last_err;

   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         last_rdata = rsp_rdata;
         last_err   = rsp_err;
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_rsp: observed rsp_valid=1 rdata %h expected no response", rsp_rdata);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("rsp_latency", cyc - e.acc, e.lat);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic preload(input int idx, input logic [31:0] val);
      @(negedge clk);
      ld_en = 1'b1; ld_idx = idx[7:0]; ld_val = val;
      ref_mem[idx] = val;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic bus_err);
      exp_t e;
      int n;
      @(negedge clk);
      req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $error("FAIL accept_timeout: observed req_ready=%b expected 1 within 50 cycles", req_ready);
         req_valid = 1'b0;
         return;
      end
      if (addr[1:0] != 2'b00) begin
         e.rdata = 32'h0; e.err = 1'b1; e.lat = 1;
      end else if (we) begin
         e.rdata = 32'h0; e.err = bus_err; e.lat = 5;
         if (!bus_err) ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wd, ws);
      end else begin
         e.rdata = ref_mem[addr[9:2]]; e.err = bus_err; e.lat = 4;
      end
      e.acc = cyc;
      sbq.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $error("FAIL drain_timeout: observed %0d pending responses expected 0", sbq.size());
         sbq.delete();
      end
      @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
      chk({tag, "_valids"}, {27'd0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int a0, w0, b0, ar0, r0, n;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      stub = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_val = '0;
      preload(4, 32'hDEADBEEF);
      preload(9, 32'h11223344);
      chk_reset("por");
      @(negedge clk);
      rst = 1'b0;

      // aligned read of preloaded word
      issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
      drain();
      chk("read_deadbeef", last_rdata, 32'hDEADBEEF);

      // full write then read-back
      issue(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0);
      issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
      drain();
      chk("readback_20", last_rdata, 32'h12345678);

      // partial write over existing word
      issue(1'b1, 32'h24, 32'hAAAABBBB, 4'h3, 1'b0);
      issue(1'b0, 32'h24, 32'h0, 4'h0, 1'b0);
      drain();
      chk("partial_24", last_rdata, 32'h1122BBBB);

      // misaligned read and write never reach the bus
      ar0 = arv_cnt; a0 = aw_cnt;
      issue(1'b0, 32'h13, 32'h0, 4'h0, 1'b0);
      issue(1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 1'b0);
      drain();
      chk("misalign_no_arvalid", arv_cnt, ar0);
      chk("misalign_no_aw", aw_cnt, a0);

      // stub slave: W before AW with SLVERR, then DECERR read
      stub = 1'b1;
      a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
      issue(1'b1, 32'h28, 32'h55555555, 4'hF, 1'b1);
      drain();
      chk("stub_aw_once", aw_cnt, a0 + 1);
      chk("stub_w_once", w_cnt, w0 + 1);
      chk("stub_b_once", b_cnt, b0 + 1);
      issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
      drain();
      chk("stub_ar_once", ar_cnt, ar0 + 1);
      chk("stub_r_once", r_cnt, r0 + 1);
      stub = 1'b0;

      // reset while in AW_W
      issue(1'b1, 32'h40, 32'h01010101, 4'hF, 1'b0);
      @(negedge clk);
      chk("aw_w_awvalid", {31'd0, bus.awvalid}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset("rst_aw_w");
      rst = 1'b0;
      sbq.delete();
      repeat (8) @(negedge clk);

      // reset while in B
      issue(1'b1, 32'h44, 32'h02020202, 4'hF, 1'b0);
      n = 0;
      while (bus.bready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_b_state", {31'd0, bus.bready}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset("rst_b");
      rst = 1'b0;
      sbq.delete();
      repeat (8) @(negedge clk);

      // back-to-back requests accepted in the response cycle
      issue(1'b1, 32'h30, 32'hA5A5C3C3, 4'hF, 1'b0);
      issue(1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
      issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
      issue(1'b1, 32'h31, 32'h0, 4'hF, 1'b0);
      issue(1'b1, 32'h34, 32'h0000BEEF, 4'h3, 1'b0);
      issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
      drain();
      chk("b2b_last", last_rdata, 32'h12345678);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_lite_mem_master.md
# axi_lite_mem_master

Bridges the core's simple single-outstanding memory request port (fetch or load/store side) onto an AXI-lite master interface. It sits directly upstream of the block-RAM AXI-lite slave. It converts one request into one AR/R or AW/W/B transaction and returns a registered one-cycle response. Misaligned accesses are rejected locally without touching the bus.

## Interface
- DATA_WIDTH, 32, data width of request and AXI data channels; fixed to 32.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; must be word aligned.
- req_wdata  in  DATA_WIDTH  write data.
- req_wstrb  in  STRB_WIDTH  write byte enables.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid for reads, 0 for writes.
- rsp_err  out  1  response error: misaligned address or AXI resp != OKAY.
- m_axi  axi_lite_if.master  —  AXI-lite master port (AR, R, AW, W, B channels).

## Operation
- States:
  - IDLE: req_ready=1.
  - AR: arvalid=1.
  - R: rready=1.
  - AW_W: awvalid / wvalid, each independently gated by its own done flag.
  - B: bready=1.
- Accept on req_valid && req_ready. Latch addr, we, wdata and wstrb into internal registers. AXI outputs are driven only from these latched values.
- Accept with req_addr[1:0] != 0:
  - stay in IDLE;
  - next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0;
  - no AXI valid asserted.
- Accepted aligned read goes to AR.
  - arvalid is held until arready. Then go to R.
  - On the R handshake: rsp_rdata <= rdata, rsp_err <= (rresp != OKAY), rsp_valid <= 1, state <= IDLE.
- Accepted aligned write goes to AW_W.
  - awvalid and wvalid are both asserted on the first cycle.
  - aw_done / w_done flags are set at the respective handshakes. Each valid drops the cycle after its handshake.
  - Handshakes in either order, or in the same cycle, are legal.
  - When both flags are done (counting handshakes in the current cycle), go to B and clear the flags.
  - On the B handshake: rsp_err <= (bresp != OKAY), rsp_rdata <= 0, rsp_valid <= 1, state <= IDLE.
- araddr and awaddr carry the latched address. wdata and wstrb carry the latched values. arprot and awprot are 0.
- rsp_valid is a single-cycle pulse. The consumer cannot stall it; there is no backpressure.
- A request offered while not in IDLE is ignored; req_ready=0 then.
- Reset outputs:
  - req_ready=1;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - all AXI valids and readies 0;
  - state IDLE, done flags 0.
- Reset mid-transaction aborts it immediately. No response is issued. The downstream slave is reset by the same event.

## Timing
- Read against the block-RAM slave, with T0 = accept edge:
  - T1: arvalid.
  - T2: arready; AR handshake.
  - T3: rvalid && rready.
  - T4: rsp_valid.
  - Accept-to-response is 4 cycles.
- Write against the block-RAM slave (it takes AW, then W, then B serially):
  - T1: awvalid+wvalid.
  - T2: AW handshake.
  - T3: W handshake.
  - T4: B handshake.
  - T5: rsp_valid.
  - Accept-to-response is 5 cycles.
- The cycle rsp_valid is high, state is IDLE and req_ready=1. A new request may be accepted in that same cycle (back-to-back).
- Misaligned request: rsp_valid one cycle after accept.
- Valids never drop before their handshake. Address and data are stable while valid is high.

## Test plan
- Aligned read, addr 0x10, RAM preloaded with 0xDEADBEEF at word 4 -> rsp_valid 4 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write addr 0x20, wdata 0x12345678, wstrb 0xF, then read 0x20 -> write rsp_valid at T5 with rsp_err=0; read returns 0x12345678.
- Partial write wstrb 0x3, wdata 0xAAAABBBB over existing 0x11223344 -> read returns 0x1122BBBB.
- Misaligned read addr 0x13 -> rsp_valid next cycle, rsp_err=1, rsp_rdata=0, no arvalid ever asserted.
- Stub slave: wready before awready, then bresp=SLVERR, rresp=DECERR on a later read -> no duplicate handshakes; rsp_err=1 on both responses.
- Assert rst during AW_W and B, and back-to-back requests at the rsp_valid cycle -> all outputs return to reset values the next cycle with no response pulse; back-to-back requests are accepted and complete in order.
